// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Each pipeline stage resolves BLKS_PER_STAGE carry-select blocks of BLOCK bits.
module pipelined_carry_select_adder #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BLOCK          = 4,
    parameter int unsigned BLKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned NBLK   = WIDTH / BLOCK;
    localparam int unsigned STAGES = NBLK / BLKS_PER_STAGE;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
    } res_t;

    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] cmsb_q, cmsb_d;
    logic [STAGES-1:0] valid_q;
    logic              stall;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

    // Resolves the blocks owned by one stage; block 0 ripples, others select on carry.
    function automatic res_t resolve(input int unsigned      stage,
                                     input logic [WIDTH-1:0] op_a,
                                     input logic [WIDTH-1:0] op_b,
                                     input logic [WIDTH-1:0] acc,
                                     input logic             cin);
        res_t             r;
        logic             c;
        logic [BLOCK-1:0] ba, bb;
        logic [BLOCK:0]   r0, r1, rs;
        int unsigned      blk;
        r.s  = acc;
        r.cm = 1'b0;
        c    = cin;
        for (int unsigned j = 0; j < BLKS_PER_STAGE; j++) begin
            blk = stage * BLKS_PER_STAGE + j;
            ba  = op_a[blk*BLOCK +: BLOCK];
            bb  = op_b[blk*BLOCK +: BLOCK];
            if (blk == 0) begin
                r0 = {1'b0, ba} + {1'b0, bb} + {{BLOCK{1'b0}}, c};
                rs = r0;
            end else begin
                r0 = {1'b0, ba} + {1'b0, bb};
                r1 = {1'b0, ba} + {1'b0, bb} + {{BLOCK{1'b0}}, 1'b1};
                rs = c ? r1 : r0;
            end
            r.s[blk*BLOCK +: BLOCK] = rs[BLOCK-1:0];
            // Carry into the block MSB falls out of sum ^ a ^ b at that bit.
            r.cm = rs[BLOCK-1] ^ ba[BLOCK-1] ^ bb[BLOCK-1];
            c    = rs[BLOCK];
        end
        r.c = c;
        return r;
    endfunction

    assign stall    = valid_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | c_in;

    always_comb begin
        res_t r;
        r          = resolve(0, a, b_eff, '0, cin_eff);
        sum_d[0]   = r.s;
        carry_d[0] = r.c;
        cmsb_d[0]  = r.cm;
        opa_d[0]   = a;
        opb_d[0]   = b_eff;
        for (int unsigned k = 1; k < STAGES; k++) begin
            r          = resolve(k, opa_q[k-1], opb_q[k-1], sum_q[k-1], carry_q[k-1]);
            sum_d[k]   = r.s;
            carry_d[k] = r.c;
            cmsb_d[k]  = r.cm;
            opa_d[k]   = opa_q[k-1];
            opb_d[k]   = opb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carry     = carry_q[STAGES-1];
    assign ovf       = carry_q[STAGES-1] ^ cmsb_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed-vector bench for pipelined_carry_select_adder (16-bit, 2 stages).
// Expected results travel through a scoreboard queue and are compared on output transfer.
module tb_pipelined_carry_select_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;

    always #5 clk = ~clk;

    pipelined_carry_select_adder #(
        .WIDTH(16),
        .BLOCK(4),
        .BLKS_PER_STAGE(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .c_in(c_in),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .carry(carry),
        .ovf(ovf)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    exp_t exp_q[$];
    exp_t pend;
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pop    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic set_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
        a        = op_a;
        b        = op_b;
        c_in     = ci;
        sub      = sb;
        in_valid = 1'b1;
        pend     = '{s: es, c: ec, o: eo};
    endtask

    // Evaluates transfers for the coming edge, then advances to the next falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            check("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("sum#%0d", n_pop), 32'(sum), 32'(e.s));
                check($sformatf("carry#%0d", n_pop), 32'(carry), 32'(e.c));
                check($sformatf("ovf#%0d", n_pop), 32'(ovf), 32'(e.o));
                n_pop++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(pend);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        check("drain_done", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[2] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        pend      = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Full carry ripple across every block, with latency check.
        set_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cycle();
        in_valid = 1'b0;
        #1 check("lat_early", 32'(out_valid), 0);
        cycle();
        check("lat_due", 32'(out_valid), 1);
        drain();

        set_op(16'h8101, 16'h8119, 1'b0, 1'b0, 16'h021A, 1'b1, 1'b1);
        cycle();
        set_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        cycle();
        set_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        cycle();
        drain();

        // Subtract; c_in must be ignored.
        set_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        cycle();
        set_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        cycle();
        drain();

        // Back-to-back stream: output valid must be continuous once the pipe fills.
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) check("stream_valid", 32'(out_valid), 1);
            set_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].s, vecs[i].c,
                   vecs[i].o);
            cycle();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            check("stream_valid", 32'(out_valid), 1);
            cycle();
        end
        check("stream_done", 32'(exp_q.size()), 0);

        // Backpressure with a full pipeline.
        set_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        cycle();
        set_op(16'hFFF0, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cycle();
        set_op(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_sum", 32'(sum), 32'h0007);
            check("stall_carry", 32'(carry), 0);
            check("stall_ovf", 32'(ovf), 0);
            cycle();
        end
        out_ready = 1'b1;
        #1 check("release_in_ready", 32'(in_ready), 1);
        cycle();
        drain();

        // Reset with two operations in flight.
        set_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        cycle();
        set_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("no_ghost", 32'(out_valid), 0);
            cycle();
        end
        set_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        #1 check("postrst_early", 32'(out_valid), 0);
        cycle();
        check("postrst_due", 32'(out_valid), 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_select_adder.md
# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake on both sides. Operands are split into equal blocks. Each block is computed twice, with carry-in 0 and with carry-in 1, and the true result is selected by the incoming block carry. Pipeline registers are inserted every `BLKS_PER_STAGE` blocks. The block is the arithmetic datapath element between the operand-issue logic and the result consumer, accepting one operation per cycle.

## Interface
- `WIDTH`, 16: operand and sum width in bits. Must be a multiple of `BLOCK`.
- `BLOCK`, 4: carry-select block width in bits.
- `BLKS_PER_STAGE`, 2: number of blocks resolved per pipeline stage. Must divide `NBLK = WIDTH/BLOCK`.
- Derived: `STAGES = NBLK/BLKS_PER_STAGE`, which is the latency in cycles.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  block can accept an operand set this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `c_in`  in  1  carry-in; ignored when `sub`=1.
- `sub`  in  1  0: a+b+c_in; 1: a−b, computed as a+~b+1.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result, modulo 2^WIDTH.
- `carry`  out  1  carry out of the MSB. In subtract mode 1 means no borrow.
- `ovf`  out  1  two's-complement overflow, i.e. the carry into the MSB XOR the carry out of the MSB.

## Operation
- Input transfer happens when `in_valid & in_ready`. Output transfer happens when `out_valid & out_ready`.
- Stall = `out_valid & ~out_ready`.
  - `in_ready = ~stall`.
  - When stalled, every pipeline register (data and valid) holds.
  - When not stalled, the whole pipeline advances one stage per cycle. An empty slot advances as valid=0.
- Operand conditioning happens at stage-0 input: `b_eff = sub ? ~b : b`, `cin_eff = sub ? 1 : c_in`.
- Block 0 uses a plain ripple add with `cin_eff`.
- Every other block computes both (sum0, c0) with carry-in 0 and (sum1, c1) with carry-in 1. A 2:1 select on the previous block's carry picks sum and carry.
- Stage k (0-based) resolves blocks k·BLKS_PER_STAGE to (k+1)·BLKS_PER_STAGE−1 using the carry registered at the end of stage k−1. Stage 0 uses `cin_eff`.
- Each stage register holds:
  - the resolved low sum bits so far;
  - the carry out of the last resolved block;
  - the carry into the last resolved MSB position, needed only by the final stage for `ovf`;
  - the unconsumed upper operand bits, already conditioned;
  - a valid bit.
- The final stage register drives `sum`, `carry` and `ovf` directly. There is no combinational path from `a`/`b` to the outputs.
- Results leave in issue order. There is no reordering or dropping.
- No X may reach the outputs: the select must be a clean 2:1 on a known carry.

## Timing
- Reset, asynchronous on the falling edge of `rst_n`:
  - all valid bits = 0, all data registers = 0;
  - therefore `out_valid`=0, `sum`=0, `carry`=0, `ovf`=0, `in_ready`=1.
- Reset mid-operation discards all in-flight operations. The first operation accepted after reset release appears after `STAGES` cycles.
- Latency: an operand set accepted at edge N is presented with `out_valid`=1 after edge N+STAGES−1, assuming no stall in between. Each stalled cycle adds one cycle.
- Throughput: one operation per cycle while `out_ready`=1.
- `in_ready` goes low combinationally in the same cycle `out_valid & ~out_ready` holds. It returns high in the cycle `out_ready` rises.
- While `out_valid`=1 and `out_ready`=0, `sum`, `carry` and `ovf` are stable.
- Simultaneous input and output transfer in the same cycle is allowed. The pipeline shifts and nothing is lost.
- Degenerate `BLKS_PER_STAGE = NBLK` gives `STAGES`=1: a single registered stage.

## Test plan
All scenarios use WIDTH=16, BLOCK=4, BLKS_PER_STAGE=2, so STAGES=2.
- Reset check: with `rst_n`=0, outputs = `out_valid` 0, `sum` 0x0000, `carry` 0, `ovf` 0, `in_ready` 1. Then a=0xFFFF, b=0x0001, c_in=0 -> after 2 cycles `sum`=0x0000, `carry`=1, `ovf`=0, exercising the carry ripple across all blocks.
- Add overflow: a=0x8101, b=0x8119 -> `sum`=0x021A, `carry`=1, `ovf`=1. Also a=0x7FFF, b=0x0001 -> `sum`=0x8000, `carry`=0, `ovf`=1.
- Subtract: `sub`=1, a=0x0005, b=0x0007, c_in=1 -> `sum`=0xFFFE, `carry`=0, `ovf`=0 (c_in ignored). Also a=0x8000, b=0x0001 -> `sum`=0x7FFF, `carry`=1, `ovf`=1.
- Back-to-back stream of 8 random operations with `out_ready`=1 -> 8 consecutive `out_valid` cycles, in order, each matching a reference model.
- Backpressure: hold `out_ready`=0 for 3 cycles with a full pipeline -> `in_ready`=0, outputs frozen, no result lost or duplicated. On release, results drain in order.
- Assert `rst_n`=0 for one cycle with 2 operations in flight -> `out_valid` drops immediately and neither result ever appears. A post-reset operation returns after 2 cycles.
